// File: rtl/matrix_window_scheduler.sv
// Line-buffer write/read sequencer and window tracker for the Sobel matrix.
// Optional short-line detection: MATRIX_WINDOW_SCHEDULER_LINE_CHECK_EN.
module matrix_window_scheduler #(
    parameter int unsigned P_FRAME_COLUMNS      = 640,
    parameter int unsigned P_FRAME_ROWS         = 480,
    parameter int unsigned P_SUBPIXEL_DEPTH     = 8,
    parameter int unsigned P_OUTPUT_MATRIX_SIZE = 3
) (
    input  logic                                 I_CLK,
    input  logic                                 I_RESET,
    input  logic                                 I_ENABLE,
    input  logic                                 I_VSYNC,
    input  logic                                 I_DATA_ENABLE,
    input  logic [P_SUBPIXEL_DEPTH-1:0]          I_PIXEL,
    output logic                                 O_WRITE_ENABLE,
    output logic [((P_OUTPUT_MATRIX_SIZE > 2) ? $clog2(P_OUTPUT_MATRIX_SIZE) : 1)-1:0] O_WRITE_BANK,
    output logic [$clog2(P_FRAME_COLUMNS)-1:0]   O_WRITE_COLUMN,
    output logic [P_SUBPIXEL_DEPTH-1:0]          O_WRITE_PIXEL,
    output logic                                 O_READ_ENABLE,
    output logic [$clog2(P_FRAME_COLUMNS)-1:0]   O_READ_COLUMN,
    output logic [((P_OUTPUT_MATRIX_SIZE > 2) ? $clog2(P_OUTPUT_MATRIX_SIZE) : 1)-1:0] O_TOP_BANK,
    output logic                                 O_WINDOW_VALID,
    output logic [$clog2(P_FRAME_COLUMNS)-1:0]   O_WINDOW_COLUMN,
    output logic [$clog2(P_FRAME_ROWS)-1:0]      O_WINDOW_ROW,
    output logic                                 O_FRAME_DONE,
    output logic                                 O_LINE_ERROR
);

    localparam int unsigned N  = P_OUTPUT_MATRIX_SIZE;
    localparam int unsigned CB = $clog2(P_FRAME_COLUMNS);
    localparam int unsigned RB = $clog2(P_FRAME_ROWS);
    localparam int unsigned BB = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

    state_t          state;
    logic [CB-1:0]   col;
    logic [RB-1:0]   row;
    logic [BB-1:0]   bank;
    logic            vsync_q;

    // Window stage: holds the accepted pixel's window until the buffer read returns
    logic            win_v;
    logic [CB-1:0]   win_col;
    logic [RB-1:0]   win_row;
    logic            done_v;

    logic            vsync_rise;
    logic            active;
    logic            accept;
    logic            col_last;
    logic            row_last;
    logic [BB-1:0]   bank_inc;
    logic [BB-1:0]   eor_bank;
    logic [RB-1:0]   eor_row;
    state_t          eor_state;

`ifdef MATRIX_WINDOW_SCHEDULER_LINE_CHECK_EN
    logic            de_q;
    logic            de_fall;
`endif

    // Frame-position decode and end-of-row successor values
    always_comb begin
        vsync_rise = I_VSYNC & ~vsync_q;
        active     = (state != S_IDLE);
        accept     = I_DATA_ENABLE & active & ~vsync_rise;
        col_last   = (col == CB'(P_FRAME_COLUMNS - 1));
        row_last   = (row == RB'(P_FRAME_ROWS - 1));
        bank_inc   = (bank == BB'(N - 1)) ? '0 : bank + BB'(1);
        eor_bank   = row_last ? '0 : bank_inc;
        eor_row    = row_last ? '0 : row + RB'(1);
        eor_state  = state;
        if (row_last)
            eor_state = S_IDLE;
        else if (row == RB'(N - 2))
            eor_state = S_STREAM;
`ifdef MATRIX_WINDOW_SCHEDULER_LINE_CHECK_EN
        de_fall    = ~I_DATA_ENABLE & de_q & active & (col != '0) & ~vsync_rise;
`endif
    end

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            state           <= S_IDLE;
            col             <= '0;
            row             <= '0;
            bank            <= '0;
            vsync_q         <= 1'b0;
            win_v           <= 1'b0;
            win_col         <= '0;
            win_row         <= '0;
            done_v          <= 1'b0;
            O_WRITE_ENABLE  <= 1'b0;
            O_WRITE_BANK    <= '0;
            O_WRITE_COLUMN  <= '0;
            O_WRITE_PIXEL   <= '0;
            O_READ_ENABLE   <= 1'b0;
            O_READ_COLUMN   <= '0;
            O_TOP_BANK      <= '0;
            O_WINDOW_VALID  <= 1'b0;
            O_WINDOW_COLUMN <= '0;
            O_WINDOW_ROW    <= '0;
            O_FRAME_DONE    <= 1'b0;
`ifdef MATRIX_WINDOW_SCHEDULER_LINE_CHECK_EN
            de_q            <= 1'b0;
            O_LINE_ERROR    <= 1'b0;
`endif
        end else if (!I_ENABLE) begin
            // Stall: drop strobes, keep counters and the window stage intact
            O_WRITE_ENABLE  <= 1'b0;
            O_READ_ENABLE   <= 1'b0;
            O_WINDOW_VALID  <= 1'b0;
            O_FRAME_DONE    <= 1'b0;
        end else begin
            vsync_q         <= I_VSYNC;
            O_WRITE_ENABLE  <= accept;
            O_READ_ENABLE   <= accept & (state == S_STREAM);
            O_WINDOW_VALID  <= win_v;
            O_WINDOW_COLUMN <= win_col;
            O_WINDOW_ROW    <= win_row;
            O_FRAME_DONE    <= done_v;
            win_v           <= 1'b0;
            done_v          <= 1'b0;
`ifdef MATRIX_WINDOW_SCHEDULER_LINE_CHECK_EN
            de_q            <= I_DATA_ENABLE;
`endif
            if (vsync_rise) begin
                state <= S_FILL;
                col   <= '0;
                row   <= '0;
                bank  <= '0;
`ifdef MATRIX_WINDOW_SCHEDULER_LINE_CHECK_EN
                O_LINE_ERROR <= 1'b0;
`endif
            end else if (accept) begin
                O_WRITE_BANK   <= bank;
                O_WRITE_COLUMN <= col;
                O_WRITE_PIXEL  <= I_PIXEL;
                O_READ_COLUMN  <= col;
                O_TOP_BANK     <= bank_inc;
                win_v          <= (state == S_STREAM) && (col >= CB'(N - 1));
                win_col        <= col - CB'(N - 1);
                win_row        <= row - RB'(N - 1);
                if (col_last) begin
                    col    <= '0;
                    row    <= eor_row;
                    bank   <= eor_bank;
                    state  <= eor_state;
                    done_v <= row_last;
                end else begin
                    col <= col + CB'(1);
                end
            end
`ifdef MATRIX_WINDOW_SCHEDULER_LINE_CHECK_EN
            else if (de_fall) begin
                // Short line: realign as though the row had completed
                O_LINE_ERROR <= 1'b1;
                col          <= '0;
                row          <= eor_row;
                bank         <= eor_bank;
                state        <= eor_state;
            end
`endif
        end
    end

`ifndef MATRIX_WINDOW_SCHEDULER_LINE_CHECK_EN
    assign O_LINE_ERROR = 1'b0;
`endif

endmodule

// File: doc/matrix_window_scheduler.md
# matrix_window_scheduler

Sequences the grayscale line buffers that feed the Sobel pixel matrix. It tracks frame position from the pixel strobe and VSYNC, then issues line-buffer write and read commands with a rotating bank index. It flags each cycle in which a complete P_OUTPUT_MATRIX_SIZE × P_OUTPUT_MATRIX_SIZE window is available, together with that window's top-left column and row. It sits between the grayscale stage and the line-buffer/matrix-shift datapath inside the colorspace converter.

## Interface
- P_FRAME_COLUMNS, 640, pixels per row
- P_FRAME_ROWS, 480, rows per frame
- P_SUBPIXEL_DEPTH, 8, grayscale pixel width
- P_OUTPUT_MATRIX_SIZE, 3, window dimension N; also the number of line-buffer banks (≥2)
- Derived widths: CB = $clog2(P_FRAME_COLUMNS), RB = $clog2(P_FRAME_ROWS), BB = max(1, $clog2(N))

Ports:
- I_CLK  in  1  clock
- I_RESET  in  1  reset; asynchronous assert, active-low
- I_ENABLE  in  1  global enable; when low, all state holds and inputs are ignored
- I_VSYNC  in  1  frame-start pulse, active-high; rising edge starts a frame
- I_DATA_ENABLE  in  1  grayscale pixel valid, one pixel per cycle
- I_PIXEL  in  P_SUBPIXEL_DEPTH  grayscale pixel
- O_WRITE_ENABLE  out  1  line-buffer write strobe
- O_WRITE_BANK  out  BB  bank being written (the newest row)
- O_WRITE_COLUMN  out  CB  write address
- O_WRITE_PIXEL  out  P_SUBPIXEL_DEPTH  registered copy of I_PIXEL
- O_READ_ENABLE  out  1  read strobe to the other N−1 banks
- O_READ_COLUMN  out  CB  read address (equals O_WRITE_COLUMN)
- O_TOP_BANK  out  BB  bank holding the oldest window row, = (O_WRITE_BANK+1) mod N
- O_WINDOW_VALID  out  1  window complete in the matrix datapath
- O_WINDOW_COLUMN  out  CB  window top-left column
- O_WINDOW_ROW  out  RB  window top-left row
- O_FRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame
- O_LINE_ERROR  out  1  sticky short-line flag (only when the macro below is defined)

## Operation
- States:
  - IDLE: ignore I_DATA_ENABLE; a VSYNC rising edge moves to FILL.
  - FILL: write rows 0..N−2 with no reads; entering row N−1 moves to STREAM.
  - STREAM: write and read; after the last pixel of row P_FRAME_ROWS−1, pulse O_FRAME_DONE and go to IDLE.
- Pixel accept: an accepted pixel is one where I_ENABLE=1, I_DATA_ENABLE=1, and the state is FILL or STREAM. Each accepted pixel is written at (col, bank), then col increments.
- End of row (col = P_FRAME_COLUMNS−1):
  - col wraps to 0 and row increments.
  - The bank advances mod N.
- Reads: asserted for every accepted pixel in STREAM. The newest row comes from O_WRITE_PIXEL, not from the buffer.
- Window: valid for an accepted pixel in STREAM with col ≥ N−1. Top-left is (col−(N−1), row−(N−1)).
- Windows per frame: (P_FRAME_COLUMNS−N+1)·(P_FRAME_ROWS−N+1).
- VSYNC rising edge while in FILL or STREAM:
  - Abort the frame: col, row and bank go to 0, state goes to FILL.
  - No O_FRAME_DONE; the pixel in that cycle is dropped.
  - VSYNC takes priority over a simultaneous I_DATA_ENABLE.
- VSYNC edge detection uses a registered previous value, updated only while I_ENABLE=1.

## Timing
- Reset values: every output, counter and state field is 0; state is IDLE; previous-VSYNC is 0.
- Pixel accepted at edge k:
  - O_WRITE_*, O_READ_* and O_TOP_BANK are valid in cycle k+1, for one cycle per accepted pixel.
  - O_WINDOW_VALID, O_WINDOW_COLUMN and O_WINDOW_ROW are valid in cycle k+2, covering the 1-cycle line-buffer read latency.
- O_FRAME_DONE asserts in cycle k+2 of the final pixel, aligned with the final window.
- I_ENABLE low: strobes deassert at the next edge; all counters and in-flight pipeline registers hold.
- Reset mid-frame: all outputs clear immediately (asynchronous); in-flight windows are discarded.
- Throughput: one pixel per cycle sustained, no backpressure.

## Configuration
- MATRIX_WINDOW_SCHEDULER_LINE_CHECK_EN defined:
  - A falling edge of I_DATA_ENABLE with col ≠ 0 in FILL/STREAM is a short line.
  - O_LINE_ERROR sets and stays set until reset or the next VSYNC rising edge.
  - col realigns to 0, row increments and the bank advances, exactly as at a normal end of row.
- Undefined: rows are delimited by pixel count only, DE falling edges are ignored, and O_LINE_ERROR is tied 0.

## Test plan
Use P_FRAME_COLUMNS=8, P_FRAME_ROWS=6, N=3 throughout.
- Reset: assert I_RESET=0 mid-stream → all outputs 0 immediately; after release, I_DATA_ENABLE without VSYNC → no O_WRITE_ENABLE.
- Full frame: VSYNC pulse, then 48 consecutive DE cycles → 48 writes, 32 reads (rows 2–5) and 24 O_WINDOW_VALID pulses.
  - First window is (0,0), two cycles after the 19th pixel; last is (5,3).
  - O_FRAME_DONE is a single pulse with the last window; state returns to IDLE.
- Bank rotation: rows 0..3 are written to banks 0,1,2,0; O_TOP_BANK=1 throughout row 3.
- Enable stall: I_ENABLE=0 for 5 cycles at row 2, col 4 with DE held high → no strobes; resume writes col 5 and the window (3,0) follows.
- Abort: VSYNC rising edge at row 3, col 2 → no O_FRAME_DONE; the next pixel is written at bank 0, col 0 with no read.
- Line check (macro defined): DE falls after 5 pixels of row 1 → O_LINE_ERROR=1; next pixel at row 2, col 0, bank 2, read enabled.
